// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, round-stage state enum and byte index helper
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Column-major AES state: byte index = 4*col + row.
  function automatic logic [3:0] byte_index(input logic [1:0] col, input logic [1:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - FIPS-197 forward S-box, one byte in, one byte out, combinational
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Forward substitution table lookup
  always_comb begin
    out_byte = 8'h00;
    case (in_byte)
      8'h00: out_byte = 8'h63; 8'h01: out_byte = 8'h7c; 8'h02: out_byte = 8'h77; 8'h03: out_byte = 8'h7b; 8'h04: out_byte = 8'hf2; 8'h05: out_byte = 8'h6b; 8'h06: out_byte = 8'h6f; 8'h07: out_byte = 8'hc5;
      8'h08: out_byte = 8'h30; 8'h09: out_byte = 8'h01; 8'h0a: out_byte = 8'h67; 8'h0b: out_byte = 8'h2b; 8'h0c: out_byte = 8'hfe; 8'h0d: out_byte = 8'hd7; 8'h0e: out_byte = 8'hab; 8'h0f: out_byte = 8'h76;
      8'h10: out_byte = 8'hca; 8'h11: out_byte = 8'h82; 8'h12: out_byte = 8'hc9; 8'h13: out_byte = 8'h7d; 8'h14: out_byte = 8'hfa; 8'h15: out_byte = 8'h59; 8'h16: out_byte = 8'h47; 8'h17: out_byte = 8'hf0;
      8'h18: out_byte = 8'had; 8'h19: out_byte = 8'hd4; 8'h1a: out_byte = 8'ha2; 8'h1b: out_byte = 8'haf; 8'h1c: out_byte = 8'h9c; 8'h1d: out_byte = 8'ha4; 8'h1e: out_byte = 8'h72; 8'h1f: out_byte = 8'hc0;
      8'h20: out_byte = 8'hb7; 8'h21: out_byte = 8'hfd; 8'h22: out_byte = 8'h93; 8'h23: out_byte = 8'h26; 8'h24: out_byte = 8'h36; 8'h25: out_byte = 8'h3f; 8'h26: out_byte = 8'hf7; 8'h27: out_byte = 8'hcc;
      8'h28: out_byte = 8'h34; 8'h29: out_byte = 8'ha5; 8'h2a: out_byte = 8'he5; 8'h2b: out_byte = 8'hf1; 8'h2c: out_byte = 8'h71; 8'h2d: out_byte = 8'hd8; 8'h2e: out_byte = 8'h31; 8'h2f: out_byte = 8'h15;
      8'h30: out_byte = 8'h04; 8'h31: out_byte = 8'hc7; 8'h32: out_byte = 8'h23; 8'h33: out_byte = 8'hc3; 8'h34: out_byte = 8'h18; 8'h35: out_byte = 8'h96; 8'h36: out_byte = 8'h05; 8'h37: out_byte = 8'h9a;
      8'h38: out_byte = 8'h07; 8'h39: out_byte = 8'h12; 8'h3a: out_byte = 8'h80; 8'h3b: out_byte = 8'he2; 8'h3c: out_byte = 8'heb; 8'h3d: out_byte = 8'h27; 8'h3e: out_byte = 8'hb2; 8'h3f: out_byte = 8'h75;
      8'h40: out_byte = 8'h09; 8'h41: out_byte = 8'h83; 8'h42: out_byte = 8'h2c; 8'h43: out_byte = 8'h1a; 8'h44: out_byte = 8'h1b; 8'h45: out_byte = 8'h6e; 8'h46: out_byte = 8'h5a; 8'h47: out_byte = 8'ha0;
      8'h48: out_byte = 8'h52; 8'h49: out_byte = 8'h3b; 8'h4a: out_byte = 8'hd6; 8'h4b: out_byte = 8'hb3; 8'h4c: out_byte = 8'h29; 8'h4d: out_byte = 8'he3; 8'h4e: out_byte = 8'h2f; 8'h4f: out_byte = 8'h84;
      8'h50: out_byte = 8'h53; 8'h51: out_byte = 8'hd1; 8'h52: out_byte = 8'h00; 8'h53: out_byte = 8'hed; 8'h54: out_byte = 8'h20; 8'h55: out_byte = 8'hfc; 8'h56: out_byte = 8'hb1; 8'h57: out_byte = 8'h5b;
      8'h58: out_byte = 8'h6a; 8'h59: out_byte = 8'hcb; 8'h5a: out_byte = 8'hbe; 8'h5b: out_byte = 8'h39; 8'h5c: out_byte = 8'h4a; 8'h5d: out_byte = 8'h4c; 8'h5e: out_byte = 8'h58; 8'h5f: out_byte = 8'hcf;
      8'h60: out_byte = 8'hd0; 8'h61: out_byte = 8'hef; 8'h62: out_byte = 8'haa; 8'h63: out_byte = 8'hfb; 8'h64: out_byte = 8'h43; 8'h65: out_byte = 8'h4d; 8'h66: out_byte = 8'h33; 8'h67: out_byte = 8'h85;
      8'h68: out_byte = 8'h45; 8'h69: out_byte = 8'hf9; 8'h6a: out_byte = 8'h02; 8'h6b: out_byte = 8'h7f; 8'h6c: out_byte = 8'h50; 8'h6d: out_byte = 8'h3c; 8'h6e: out_byte = 8'h9f; 8'h6f: out_byte = 8'ha8;
      8'h70: out_byte = 8'h51; 8'h71: out_byte = 8'ha3; 8'h72: out_byte = 8'h40; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'h92; 8'h75: out_byte = 8'h9d; 8'h76: out_byte = 8'h38; 8'h77: out_byte = 8'hf5;
      8'h78: out_byte = 8'hbc; 8'h79: out_byte = 8'hb6; 8'h7a: out_byte = 8'hda; 8'h7b: out_byte = 8'h21; 8'h7c: out_byte = 8'h10; 8'h7d: out_byte = 8'hff; 8'h7e: out_byte = 8'hf3; 8'h7f: out_byte = 8'hd2;
      8'h80: out_byte = 8'hcd; 8'h81: out_byte = 8'h0c; 8'h82: out_byte = 8'h13; 8'h83: out_byte = 8'hec; 8'h84: out_byte = 8'h5f; 8'h85: out_byte = 8'h97; 8'h86: out_byte = 8'h44; 8'h87: out_byte = 8'h17;
      8'h88: out_byte = 8'hc4; 8'h89: out_byte = 8'ha7; 8'h8a: out_byte = 8'h7e; 8'h8b: out_byte = 8'h3d; 8'h8c: out_byte = 8'h64; 8'h8d: out_byte = 8'h5d; 8'h8e: out_byte = 8'h19; 8'h8f: out_byte = 8'h73;
      8'h90: out_byte = 8'h60; 8'h91: out_byte = 8'h81; 8'h92: out_byte = 8'h4f; 8'h93: out_byte = 8'hdc; 8'h94: out_byte = 8'h22; 8'h95: out_byte = 8'h2a; 8'h96: out_byte = 8'h90; 8'h97: out_byte = 8'h88;
      8'h98: out_byte = 8'h46; 8'h99: out_byte = 8'hee; 8'h9a: out_byte = 8'hb8; 8'h9b: out_byte = 8'h14; 8'h9c: out_byte = 8'hde; 8'h9d: out_byte = 8'h5e; 8'h9e: out_byte = 8'h0b; 8'h9f: out_byte = 8'hdb;
      8'ha0: out_byte = 8'he0; 8'ha1: out_byte = 8'h32; 8'ha2: out_byte = 8'h3a; 8'ha3: out_byte = 8'h0a; 8'ha4: out_byte = 8'h49; 8'ha5: out_byte = 8'h06; 8'ha6: out_byte = 8'h24; 8'ha7: out_byte = 8'h5c;
      8'ha8: out_byte = 8'hc2; 8'ha9: out_byte = 8'hd3; 8'haa: out_byte = 8'hac; 8'hab: out_byte = 8'h62; 8'hac: out_byte = 8'h91; 8'had: out_byte = 8'h95; 8'hae: out_byte = 8'he4; 8'haf: out_byte = 8'h79;
      8'hb0: out_byte = 8'he7; 8'hb1: out_byte = 8'hc8; 8'hb2: out_byte = 8'h37; 8'hb3: out_byte = 8'h6d; 8'hb4: out_byte = 8'h8d; 8'hb5: out_byte = 8'hd5; 8'hb6: out_byte = 8'h4e; 8'hb7: out_byte = 8'ha9;
      8'hb8: out_byte = 8'h6c; 8'hb9: out_byte = 8'h56; 8'hba: out_byte = 8'hf4; 8'hbb: out_byte = 8'hea; 8'hbc: out_byte = 8'h65; 8'hbd: out_byte = 8'h7a; 8'hbe: out_byte = 8'hae; 8'hbf: out_byte = 8'h08;
      8'hc0: out_byte = 8'hba; 8'hc1: out_byte = 8'h78; 8'hc2: out_byte = 8'h25; 8'hc3: out_byte = 8'h2e; 8'hc4: out_byte = 8'h1c; 8'hc5: out_byte = 8'ha6; 8'hc6: out_byte = 8'hb4; 8'hc7: out_byte = 8'hc6;
      8'hc8: out_byte = 8'he8; 8'hc9: out_byte = 8'hdd; 8'hca: out_byte = 8'h74; 8'hcb: out_byte = 8'h1f; 8'hcc: out_byte = 8'h4b; 8'hcd: out_byte = 8'hbd; 8'hce: out_byte = 8'h8b; 8'hcf: out_byte = 8'h8a;
      8'hd0: out_byte = 8'h70; 8'hd1: out_byte = 8'h3e; 8'hd2: out_byte = 8'hb5; 8'hd3: out_byte = 8'h66; 8'hd4: out_byte = 8'h48; 8'hd5: out_byte = 8'h03; 8'hd6: out_byte = 8'hf6; 8'hd7: out_byte = 8'h0e;
      8'hd8: out_byte = 8'h61; 8'hd9: out_byte = 8'h35; 8'hda: out_byte = 8'h57; 8'hdb: out_byte = 8'hb9; 8'hdc: out_byte = 8'h86; 8'hdd: out_byte = 8'hc1; 8'hde: out_byte = 8'h1d; 8'hdf: out_byte = 8'h9e;
      8'he0: out_byte = 8'he1; 8'he1: out_byte = 8'hf8; 8'he2: out_byte = 8'h98; 8'he3: out_byte = 8'h11; 8'he4: out_byte = 8'h69; 8'he5: out_byte = 8'hd9; 8'he6: out_byte = 8'h8e; 8'he7: out_byte = 8'h94;
      8'he8: out_byte = 8'h9b; 8'he9: out_byte = 8'h1e; 8'hea: out_byte = 8'h87; 8'heb: out_byte = 8'he9; 8'hec: out_byte = 8'hce; 8'hed: out_byte = 8'h55; 8'hee: out_byte = 8'h28; 8'hef: out_byte = 8'hdf;
      8'hf0: out_byte = 8'h8c; 8'hf1: out_byte = 8'ha1; 8'hf2: out_byte = 8'h89; 8'hf3: out_byte = 8'h0d; 8'hf4: out_byte = 8'hbf; 8'hf5: out_byte = 8'he6; 8'hf6: out_byte = 8'h42; 8'hf7: out_byte = 8'h68;
      8'hf8: out_byte = 8'h41; 8'hf9: out_byte = 8'h99; 8'hfa: out_byte = 8'h2d; 8'hfb: out_byte = 8'h0f; 8'hfc: out_byte = 8'hb0; 8'hfd: out_byte = 8'h54; 8'hfe: out_byte = 8'hbb; 8'hff: out_byte = 8'h16;
    endcase
  end

endmodule

// File: rtl/subbytes_seq.sv
// rtl/subbytes_seq.sv - iterative AES SubBytes stage, BYTES_PER_CYCLE S-boxes per clock
module subbytes_seq
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:AES_STATE_W-1] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:AES_STATE_W-1] out_data,
  output logic                 busy
);

  localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [0:AES_STATE_W-1]  st_q, st_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;

  logic [3:0]            byte_idx [BYTES_PER_CYCLE];
  logic [AES_BYTE_W-1:0] sb_in    [BYTES_PER_CYCLE];
  logic [AES_BYTE_W-1:0] sb_out   [BYTES_PER_CYCLE];

  // Select the bytes handled in the current step: cnt*B .. cnt*B+B-1
  always_comb begin
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      byte_idx[j] = 4'(int'(cnt_q) * BYTES_PER_CYCLE + j);
      sb_in[j]    = st_q[{byte_idx[j], 3'b000} +: AES_BYTE_W];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sb_in[g]),
      .out_byte (sb_out[g])
    );
  end

  // A new state is taken when idle, or in the same edge the finished one is handed off
  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);

  // Next state, step counter and in-place byte substitution
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
          st_d[{byte_idx[j], 3'b000} +: AES_BYTE_W] = sb_out[j];
        end
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            st_d    = in_data;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == BUSY);
  end

  // State registers; outputs are registered alongside the FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // A partially substituted state never leaves the block
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? st_q : '0;
  assign busy      = busy_q;

endmodule

// File: tb/tb_subbytes_seq.sv
// tb/tb_subbytes_seq.sv - self-checking bench for subbytes_seq with a scoreboard queue
module tb_subbytes_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [0:127] out_data;
  logic         busy;

  logic         sw_valid = 1'b0;
  logic [0:127] sw_data = '0;
  logic         sw_ready = 1'b1;
  logic [3:0]   sw_ir;
  logic [3:0]   sw_ov;
  logic [3:0]   sw_bz;
  logic [0:127] sw_od [4];

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb_ref [256];
  logic [0:127] exp_q [$];

  localparam logic [0:127] VEC_IN     = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [0:127] VEC_OUT    = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [0:127] CORNER_IN  = 128'h0053ff010053ff010053ff010053ff01;
  localparam logic [0:127] CORNER_OUT = 128'h63ed167c63ed167c63ed167c63ed167c;

  always #5 clk = ~clk;

  subbytes_seq #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  subbytes_seq #(.BYTES_PER_CYCLE(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[0]), .in_data(sw_data),
    .out_valid(sw_ov[0]), .out_ready(sw_ready), .out_data(sw_od[0]), .busy(sw_bz[0])
  );
  subbytes_seq #(.BYTES_PER_CYCLE(2)) dut_b2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[1]), .in_data(sw_data),
    .out_valid(sw_ov[1]), .out_ready(sw_ready), .out_data(sw_od[1]), .busy(sw_bz[1])
  );
  subbytes_seq #(.BYTES_PER_CYCLE(8)) dut_b8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[2]), .in_data(sw_data),
    .out_valid(sw_ov[2]), .out_ready(sw_ready), .out_data(sw_od[2]), .busy(sw_bz[2])
  );
  subbytes_seq #(.BYTES_PER_CYCLE(16)) dut_b16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[3]), .in_data(sw_data),
    .out_valid(sw_ov[3]), .out_ready(sw_ready), .out_data(sw_od[3]), .busy(sw_bz[3])
  );

  // Reference S-box built from GF(2^8) inversion plus the affine map
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_ref;
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb_ref[x] = s;
    end
  endtask

  function automatic logic [0:127] model(input logic [0:127] d);
    logic [0:127] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb_ref[d[8*i +: 8]];
    return r;
  endfunction

  // Drive one state into the main DUT from IDLE; returns at the negedge after the accept edge
  task automatic accept_one(input logic [0:127] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    exp_q.push_back(model(d));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Count edges until out_valid; bounded so a dead DUT yields a wrong latency
  task automatic wait_out(output int lat);
    lat = 0;
    #1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic take_out;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_vector;
    int lat;
    logic [0:127] exp;
    accept_one(VEC_IN);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL vec_busy got=%b want=1", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL vec_busy_in_ready got=%b want=0", in_ready); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL vec_busy_out_data got=%h want=0", out_data); end
    wait_out(lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL vec_latency got=%0d want=4", lat); end
    exp = exp_q.pop_front();
    total++; if (out_data !== exp) begin bad++; $display("FAIL vec_data got=%h want=%h", out_data, exp); end
    total++; if (out_data !== VEC_OUT) begin bad++; $display("FAIL vec_fips got=%h want=%h", out_data, VEC_OUT); end
    take_out();
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL vec_idle got=%b%b want=01", out_valid, in_ready); end
  endtask

  task automatic test_corners;
    int lat;
    logic [0:127] exp;
    accept_one(CORNER_IN);
    wait_out(lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL corner_latency got=%0d want=4", lat); end
    exp = exp_q.pop_front();
    total++; if (out_data !== exp) begin bad++; $display("FAIL corner_data got=%h want=%h", out_data, exp); end
    total++; if (out_data !== CORNER_OUT) begin bad++; $display("FAIL corner_table got=%h want=%h", out_data, CORNER_OUT); end
    take_out();
  endtask

  task automatic test_reset_mid;
    int seen;
    accept_one(VEC_IN);
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_output got=%0d want=0", seen); end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [0:127] exp;
    accept_one(VEC_IN);
    wait_out(lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL bp_latency got=%0d want=4", lat); end
    in_valid = 1'b1;
    in_data  = CORNER_IN;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if (out_data !== exp_q[0]) begin bad++; $display("FAIL bp_stable cyc=%0d got=%h want=%h", i, out_data, exp_q[0]); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
      total++; if (out_valid !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b%b want=10", i, out_valid, busy); end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    exp = exp_q.pop_front();
    total++; if (out_data !== exp) begin bad++; $display("FAIL bp_data got=%h want=%h", out_data, exp); end
    @(posedge clk);
    exp_q.push_back(model(CORNER_IN));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_handoff got=%b%b want=10", busy, out_valid); end
    wait_out(lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL bp2_latency got=%0d want=4", lat); end
    exp = exp_q.pop_front();
    total++; if (out_data !== exp) begin bad++; $display("FAIL bp2_data got=%h want=%h", out_data, exp); end
    take_out();
  endtask

  task automatic test_streaming;
    logic [0:127] blk [3];
    logic [0:127] exp;
    int idx, nout, ncyc, last;
    logic take;
    for (int i = 0; i < 3; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
    idx = 0; nout = 0; ncyc = 0; last = 0;
    out_ready = 1'b1;
    while (nout < 3 && ncyc < 100) begin
      @(negedge clk);
      in_valid = (idx < 3);
      if (idx < 3) in_data = blk[idx];
      #1;
      if (out_valid) begin
        exp = exp_q.pop_front();
        total++; if (out_data !== exp) begin bad++; $display("FAIL stream_data blk=%0d got=%h want=%h", nout, out_data, exp); end
        if (nout > 0) begin
          total++; if (ncyc - last !== 5) begin bad++; $display("FAIL stream_period blk=%0d got=%0d want=5", nout, ncyc - last); end
        end
        last = ncyc;
        nout++;
      end
      take = in_valid & in_ready;
      @(posedge clk);
      ncyc++;
      if (take) begin
        exp_q.push_back(model(blk[idx]));
        idx++;
      end
    end
    total++; if (nout !== 3) begin bad++; $display("FAIL stream_count got=%0d want=3", nout); end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_sweep;
    int want_lat [4];
    int seen_lat [4];
    logic [0:127] seen_d [4];
    want_lat = '{16, 8, 2, 1};
    for (int k = 0; k < 4; k++) begin seen_lat[k] = 0; seen_d[k] = '0; end
    @(negedge clk);
    sw_valid = 1'b1;
    sw_data  = VEC_IN;
    @(posedge clk);
    @(negedge clk);
    sw_valid = 1'b0;
    sw_data  = {$urandom, $urandom, $urandom, $urandom};
    #1;
    total++; if (sw_bz !== 4'b1111 || sw_ir !== 4'b0000) begin bad++; $display("FAIL sweep_busy got=%b/%b want=1111/0000", sw_bz, sw_ir); end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (sw_ov[k] && seen_lat[k] == 0) begin
          seen_lat[k] = cyc;
          seen_d[k]   = sw_od[k];
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++; if (seen_lat[k] !== want_lat[k]) begin bad++; $display("FAIL sweep_latency inst=%0d got=%0d want=%0d", k, seen_lat[k], want_lat[k]); end
      total++; if (seen_d[k] !== VEC_OUT) begin bad++; $display("FAIL sweep_data inst=%0d got=%h want=%h", k, seen_d[k], VEC_OUT); end
    end
  endtask

  initial begin
    build_ref();
    test_reset();
    test_vector();
    test_corners();
    test_reset_mid();
    test_backpressure();
    test_streaming();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
